// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit:
// FSM state encoding, datapath widths and the default memory timeout.
package instr_fetch_pkg;

    localparam int XLEN             = 32;
    localparam int ILEN             = 32;
    localparam int IMEM_TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FULL,
        DRAIN,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory read bus between fetch (master) and memory (slave).
// Signals: imem_req/imem_addr from fetch; imem_ack/imem_rdata from memory.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timer.sv
// Cycle counter for an outstanding memory read.
// Ports: clk, rst, clear, enable, limit -> expired (this is the limit-th cycle).
module fetch_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // High during the cycle that would be the limit-th cycle without ack.
    assign expired = enable && (count == limit - 1'b1);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding read, single-entry output buffer.
// Ports: clk, rst, pc_in/pc_take, imem (bus master), instr/instr_pc/
// instr_valid/instr_ready to decode, flush, sticky fetch_err.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int IMEM_TIMEOUT = IMEM_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pc_in,
    output logic               pc_take,
    instr_fetch_if.master      imem,
    output logic [ILEN-1:0]    instr,
    output logic [XLEN-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               flush,
    output logic               fetch_err
);

    localparam int CW = $clog2(IMEM_TIMEOUT + 1);

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [XLEN-1:0] addr_reg;
    logic [ILEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic            err_q;

    logic            take;
    logic            load_instr;
    logic            tmr_clr;
    logic            tmr_en;
    logic            tmr_exp;
    logic            busy;

    fetch_timer #(
        .W (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .limit   (CW'(IMEM_TIMEOUT)),
        .expired (tmr_exp)
    );

    always_comb begin
        state_next = state;
        take       = 1'b0;
        load_instr = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!flush) begin
                    take       = 1'b1;
                    tmr_clr    = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    // Flushed request still owns the bus until its ack.
                    if (imem.imem_ack) begin
                        state_next = IDLE;
                    end else begin
                        tmr_clr    = 1'b1;
                        state_next = DRAIN;
                    end
                end else if (imem.imem_ack) begin
                    load_instr = 1'b1;
                    state_next = FULL;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_next = ERR;
                    end
                end
            end
            DRAIN: begin
                if (imem.imem_ack) begin
                    state_next = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_exp) begin
                        state_next = ERR;
                    end
                end
            end
            FULL: begin
                if (instr_ready || flush) begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_reg <= '0;
            instr_q  <= '0;
            pc_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (take) begin
                addr_reg <= pc_in;
            end
            if (load_instr) begin
                instr_q <= imem.imem_rdata;
                pc_q    <= addr_reg;
            end
            if (state_next == ERR) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy           = (state == WAIT) || (state == DRAIN);
    assign imem.imem_req  = busy;
    assign imem.imem_addr = busy ? addr_reg : '0;

    // IDLE would otherwise pulse pc_take while reset is held.
    assign pc_take     = take && !rst;
    assign instr_valid = (state == FULL) && !flush;
    assign instr       = (state == ERR) ? '0 : instr_q;
    assign instr_pc    = (state == ERR) ? '0 : pc_q;
    assign fetch_err   = err_q;

endmodule
